ec_point_add: RTL and testbench
===============================

EC_POINT_ADD -- requirements
Module: ec_point_add

Interface
REQ-001 SHALL have parameter W, default 5, meaning field-element width in bits.
REQ-002 SHALL have parameter B, default 7, meaning curve constant b of y^2 = x^3 + b (a = 0).
REQ-003 SHALL have port Clk  input  1  system clock, all state on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request an operation; sampled only in IDLE.
REQ-006 SHALL have port p  input  W  field prime (odd, >3).
REQ-007 SHALL have ports x1, y1  input  W each  operand P coordinates.
REQ-008 SHALL have port inf1  input  1  P is the point at infinity.
REQ-009 SHALL have ports x2, y2  input  W each  operand Q coordinates.
REQ-010 SHALL have port inf2  input  1  Q is the point at infinity.
REQ-011 SHALL have ports x3, y3  output  W each  result R = P + Q.
REQ-012 SHALL have port inf3  output  1  R is the point at infinity.
REQ-013 SHALL have port busy  output  1  operation in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-015 SHALL have port err  output  1  operand coordinate not < p; valid with done.

Function
REQ-016 SHALL implement FSM states IDLE, CHECK, PREP, INV, LAMBDA, CALC_X, CALC_Y, FINISH.
REQ-017 SHALL, in IDLE with start=1, register p, x1, y1, inf1, x2, y2, inf2, assert busy, and go to CHECK next cycle.
REQ-018 SHALL ignore start while busy=1; registered operands SHALL not change mid-operation.
REQ-019 SHALL, in CHECK, resolve special cases straight to FINISH: any non-infinite coordinate >= p -> err=1, inf3=1, x3=y3=0.
REQ-020 SHALL resolve the remaining special cases in CHECK: inf1 -> R=Q; inf2 -> R=P; x1==x2 with y1!=y2 -> inf3=1; P==Q with y1==0 -> inf3=1.
REQ-021 SHALL, otherwise, compute in PREP the numerator/denominator: add num=(y2-y1) mod p, den=(x2-x1) mod p; double num=3*x1^2 mod p, den=2*y1 mod p.
REQ-022 SHALL compute den^-1 in INV as den^(p-2) mod p by MSB-first square-and-multiply over W exponent bits.
REQ-023 SHALL perform every modular multiply with one shared sequential shift-add multiplier: W+1 cycles per product, W+1-bit intermediates, conditional subtract of p each step.
REQ-024 SHALL compute lambda = num*den^-1, x3 = lambda^2 - x1 - x2, y3 = lambda*(x1 - x3) - y1, all mod p, with results in [0, p-1].
REQ-025 SHALL, in FINISH, update x3/y3/inf3/err, pulse done for exactly one cycle, deassert busy, and return to IDLE.
REQ-026 SHALL hold x3, y3, inf3 and err stable from done until the next done.
REQ-027 SHALL assert done no more than 4*W*(W+2)+32 cycles after start is accepted (172 for W=5).
REQ-028 SHALL accept a new start in the cycle after done, back-to-back.

Reset
REQ-029 SHALL, on Reset=1 at any time including mid-operation, immediately enter IDLE and drive x3=y3=0, inf3=0, busy=0, done=0, err=0.
REQ-030 SHALL not produce done for an operation aborted by reset.

Verification (p=17, B=7, W=5)
REQ-031 SHALL check add: P=(1,5), Q=(2,7) -> done with R=(1,12), inf3=0, err=0.
REQ-032 SHALL check doubling: P=Q=(1,5) -> R=(2,10); P=Q=(5,8) -> R=(5,9).
REQ-033 SHALL check infinity cases: (1,5)+(1,12) -> inf3=1; (3,0)+(3,0) -> inf3=1; inf1=1, Q=(2,7) -> R=(2,7) within 4 cycles of start.
REQ-034 SHALL check error: x1=18 -> done, err=1, inf3=1.
REQ-035 SHALL check reset abort: assert Reset 20 cycles into (1,5)+(2,7) -> busy=0, outputs zero, no done; then a fresh start yields (1,12).
REQ-036 SHALL check that start pulsed while busy is ignored, and that back-to-back starts each give exactly one done pulse within 172 cycles.

Source files
------------

// File: rtl/ec_point_add.sv
// Elliptic-curve point addition/doubling over GF(p) for y^2 = x^3 + b (a = 0).
// All modular products share one sequential MSB-first shift-add multiplier.
module ec_point_add #(
  parameter int unsigned W = 5,
  parameter int unsigned B = 7
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [W-1:0] p,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  input  logic         inf1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] y2,
  input  logic         inf2,
  output logic [W-1:0] x3,
  output logic [W-1:0] y3,
  output logic         inf3,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  // b cancels out of the a=0 add/double formulas; only its range is sanity-checked here.
  if (B >= (64'd1 << W)) begin : g_b_wider_than_field
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PREP, S_INV, S_LAMBDA, S_CALC_X, S_CALC_Y, S_FINISH
  } state_t;

  // (a + b) mod m for a, b < m
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[W-1:0];
  endfunction

  // (a - b) mod m for a, b < m
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [W:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + {1'b0, m};
    return s[W-1:0];
  endfunction

  state_t         state_q, state_d;
  logic [W-1:0]   p_q, p_d, x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic           inf1_q, inf1_d, inf2_q, inf2_d, dbl_q, dbl_d;
  logic [W-1:0]   num_q, num_d, den_q, den_d, r_q, r_d, lam_q, lam_d;
  logic [CW-1:0]  bit_q, bit_d;
  logic           mphase_q, mphase_d;
  logic [W-1:0]   rx_q, rx_d, ry_q, ry_d;
  logic           rinf_q, rinf_d, rerr_q, rerr_d;
  logic [W-1:0]   x3_q, x3_d, y3_q, y3_d;
  logic           inf3_q, inf3_d, err_q, err_d, busy_q, busy_d, done_q, done_d;

  logic [W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_acc_q, mul_acc_d;
  logic [CW-1:0]  mul_cnt_q, mul_cnt_d;
  logic           mul_run_q, mul_run_d;
  logic           mul_go_c, mul_done_c;
  logic [W-1:0]   mul_a_c, mul_b_c, mul_res_c;
  logic [W:0]     mul_t, mul_u;

  logic [W-1:0]   exp_c;
  logic           coord_bad_c;

  assign exp_c = p_q - W'(2);
  assign coord_bad_c = (!inf1_q && ((x1_q >= p_q) || (y1_q >= p_q))) ||
                       (!inf2_q && ((x2_q >= p_q) || (y2_q >= p_q)));

  // One multiplier step: acc = 2*acc (+ a if current b bit) mod p, MSB first
  always_comb begin
    mul_t = {mul_acc_q, 1'b0};
    if (mul_t >= {1'b0, p_q}) mul_t = mul_t - {1'b0, p_q};
    mul_u = mul_t + (mul_b_q[mul_cnt_q] ? {1'b0, mul_a_q} : '0);
    if (mul_u >= {1'b0, p_q}) mul_u = mul_u - {1'b0, p_q};
    mul_res_c  = mul_u[W-1:0];
    mul_done_c = mul_run_q && (mul_cnt_q == '0);
  end

  // Multiplier sequencing: load on go, then W step cycles
  always_comb begin
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_acc_d = mul_acc_q;
    mul_cnt_d = mul_cnt_q;
    mul_run_d = mul_run_q;
    if (mul_go_c) begin
      mul_a_d   = mul_a_c;
      mul_b_d   = mul_b_c;
      mul_acc_d = '0;
      mul_cnt_d = CW'(W - 1);
      mul_run_d = 1'b1;
    end else if (mul_run_q) begin
      mul_acc_d = mul_res_c;
      mul_cnt_d = mul_cnt_q - CW'(1);
      if (mul_cnt_q == '0) mul_run_d = 1'b0;
    end
  end

  // Main control: special cases, slope, inversion and result assembly
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    inf1_d   = inf1_q;
    x2_d     = x2_q;
    y2_d     = y2_q;
    inf2_d   = inf2_q;
    dbl_d    = dbl_q;
    num_d    = num_q;
    den_d    = den_q;
    r_d      = r_q;
    lam_d    = lam_q;
    bit_d    = bit_q;
    mphase_d = mphase_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    rinf_d   = rinf_q;
    rerr_d   = rerr_q;
    x3_d     = x3_q;
    y3_d     = y3_q;
    inf3_d   = inf3_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mul_go_c = 1'b0;
    mul_a_c  = '0;
    mul_b_c  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          p_d     = p;
          x1_d    = x1;
          y1_d    = y1;
          inf1_d  = inf1;
          x2_d    = x2;
          y2_d    = y2;
          inf2_d  = inf2;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        rx_d    = '0;
        ry_d    = '0;
        rinf_d  = 1'b0;
        rerr_d  = 1'b0;
        state_d = S_FINISH;
        if (coord_bad_c) begin
          rerr_d = 1'b1;
          rinf_d = 1'b1;
        end else if (inf1_q) begin
          rinf_d = inf2_q;
          rx_d   = inf2_q ? '0 : x2_q;
          ry_d   = inf2_q ? '0 : y2_q;
        end else if (inf2_q) begin
          rx_d = x1_q;
          ry_d = y1_q;
        end else if ((x1_q == x2_q) && ((y1_q != y2_q) || (y1_q == '0))) begin
          rinf_d = 1'b1;
        end else begin
          dbl_d   = (x1_q == x2_q);
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (!dbl_q) begin
          num_d    = mod_sub(y2_q, y1_q, p_q);
          den_d    = mod_sub(x2_q, x1_q, p_q);
          r_d      = W'(1);
          bit_d    = CW'(W - 1);
          mphase_d = 1'b0;
          state_d  = S_INV;
        end else if (!mul_run_q) begin
          mul_go_c = 1'b1;
          mul_a_c  = x1_q;
          mul_b_c  = x1_q;
        end else if (mul_done_c) begin
          num_d    = mod_add(mod_add(mul_res_c, mul_res_c, p_q), mul_res_c, p_q);
          den_d    = mod_add(y1_q, y1_q, p_q);
          r_d      = W'(1);
          bit_d    = CW'(W - 1);
          mphase_d = 1'b0;
          state_d  = S_INV;
        end
      end
      S_INV: begin
        if (!mul_run_q) begin
          mul_go_c = 1'b1;
          mul_a_c  = r_q;
          mul_b_c  = mphase_q ? den_q : r_q;
        end else if (mul_done_c) begin
          r_d = mul_res_c;
          if (!mphase_q && exp_c[bit_q]) begin
            mphase_d = 1'b1;
          end else begin
            mphase_d = 1'b0;
            if (bit_q == '0) state_d = S_LAMBDA;
            else             bit_d   = bit_q - CW'(1);
          end
        end
      end
      S_LAMBDA: begin
        if (!mul_run_q) begin
          mul_go_c = 1'b1;
          mul_a_c  = num_q;
          mul_b_c  = r_q;
        end else if (mul_done_c) begin
          lam_d   = mul_res_c;
          state_d = S_CALC_X;
        end
      end
      S_CALC_X: begin
        if (!mul_run_q) begin
          mul_go_c = 1'b1;
          mul_a_c  = lam_q;
          mul_b_c  = lam_q;
        end else if (mul_done_c) begin
          rx_d    = mod_sub(mod_sub(mul_res_c, x1_q, p_q), x2_q, p_q);
          state_d = S_CALC_Y;
        end
      end
      S_CALC_Y: begin
        if (!mul_run_q) begin
          mul_go_c = 1'b1;
          mul_a_c  = lam_q;
          mul_b_c  = mod_sub(x1_q, rx_q, p_q);
        end else if (mul_done_c) begin
          ry_d    = mod_sub(mul_res_c, y1_q, p_q);
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        x3_d    = rx_q;
        y3_d    = ry_q;
        inf3_d  = rinf_q;
        err_d   = rerr_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      inf1_q    <= 1'b0;
      x2_q      <= '0;
      y2_q      <= '0;
      inf2_q    <= 1'b0;
      dbl_q     <= 1'b0;
      num_q     <= '0;
      den_q     <= '0;
      r_q       <= '0;
      lam_q     <= '0;
      bit_q     <= '0;
      mphase_q  <= 1'b0;
      rx_q      <= '0;
      ry_q      <= '0;
      rinf_q    <= 1'b0;
      rerr_q    <= 1'b0;
      x3_q      <= '0;
      y3_q      <= '0;
      inf3_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_acc_q <= '0;
      mul_cnt_q <= '0;
      mul_run_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      inf1_q    <= inf1_d;
      x2_q      <= x2_d;
      y2_q      <= y2_d;
      inf2_q    <= inf2_d;
      dbl_q     <= dbl_d;
      num_q     <= num_d;
      den_q     <= den_d;
      r_q       <= r_d;
      lam_q     <= lam_d;
      bit_q     <= bit_d;
      mphase_q  <= mphase_d;
      rx_q      <= rx_d;
      ry_q      <= ry_d;
      rinf_q    <= rinf_d;
      rerr_q    <= rerr_d;
      x3_q      <= x3_d;
      y3_q      <= y3_d;
      inf3_q    <= inf3_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_acc_q <= mul_acc_d;
      mul_cnt_q <= mul_cnt_d;
      mul_run_q <= mul_run_d;
    end
  end

  assign x3   = x3_q;
  assign y3   = y3_q;
  assign inf3 = inf3_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ec_point_add.sv
// Directed bench for ec_point_add on p=17, b=7, W=5 with hand-computed results.
module tb_ec_point_add;

  localparam int unsigned W = 5;
  localparam int MAX_LAT = 172;

  logic         Clk;
  logic         Reset;
  logic         start;
  logic [W-1:0] p, x1, y1, x2, y2;
  logic         inf1, inf2;
  logic [W-1:0] x3, y3;
  logic         inf3, busy, done, err;

  int n_checks;
  int n_fail;

  ec_point_add #(.W(W), .B(7)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .p(p),
    .x1(x1), .y1(y1), .inf1(inf1), .x2(x2), .y2(y2), .inf2(inf2),
    .x3(x3), .y3(y3), .inf3(inf3), .busy(busy), .done(done), .err(err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Count one comparison and report it when observed differs from expected
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Launch one operation and check its result; b2b starts in the current (done) cycle
  task automatic run_op(input string tag,
                        input int ax1, input int ay1, input bit ai1,
                        input int ax2, input int ay2, input bit ai2,
                        input int ex, input int ey, input bit einf, input bit eerr,
                        input int max_lat, input bit b2b, input int glitch_at);
    int lat;
    bit seen;
    if (!b2b) @(negedge Clk);
    x1 = W'(ax1); y1 = W'(ay1); inf1 = ai1;
    x2 = W'(ax2); y2 = W'(ay2); inf2 = ai2;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    lat = 1;
    seen = 1'b0;
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
    while (lat < 250) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (lat == glitch_at) begin
        start = 1'b1;
        x1 = W'(3); y1 = W'(0); x2 = W'(3); y2 = W'(0); inf1 = 1'b1; inf2 = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge Clk);
      lat++;
    end
    start = 1'b0;
    check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_val({tag, "_latency_ok"}, 32'(lat <= max_lat), 32'd1);
    check_val({tag, "_inf3"}, 32'(inf3), 32'(einf));
    check_val({tag, "_err"}, 32'(err), 32'(eerr));
    if (!einf || eerr) begin
      check_val({tag, "_x3"}, 32'(x3), 32'(ex));
      check_val({tag, "_y3"}, 32'(y3), 32'(ey));
    end
  endtask

  // done is a single-cycle pulse and the result holds afterwards
  task automatic hold_check(input string tag, input int ex, input int ey,
                            input bit einf, input bit eerr);
    @(negedge Clk);
    check_val({tag, "_done_width"}, 32'(done), 32'd0);
    check_val({tag, "_busy_clear"}, 32'(busy), 32'd0);
    repeat (5) @(negedge Clk);
    check_val({tag, "_hold_x3"}, 32'(x3), 32'(ex));
    check_val({tag, "_hold_y3"}, 32'(y3), 32'(ey));
    check_val({tag, "_hold_inf3"}, 32'(inf3), 32'(einf));
    check_val({tag, "_hold_err"}, 32'(err), 32'(eerr));
    check_val({tag, "_no_extra_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    n_checks = 0;
    n_fail = 0;
    Reset = 1'b1;
    start = 1'b0;
    p = W'(17);
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; inf1 = 1'b0; inf2 = 1'b0;
    repeat (3) @(negedge Clk);
    check_val("rst_x3", 32'(x3), 32'd0);
    check_val("rst_y3", 32'(y3), 32'd0);
    check_val("rst_inf3", 32'(inf3), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    Reset = 1'b0;

    run_op("add", 1, 5, 0, 2, 7, 0, 1, 12, 0, 0, MAX_LAT, 0, -1);
    hold_check("add", 1, 12, 0, 0);
    run_op("dbl_1_5", 1, 5, 0, 1, 5, 0, 2, 10, 0, 0, MAX_LAT, 0, -1);
    run_op("dbl_5_8_b2b", 5, 8, 0, 5, 8, 0, 5, 9, 0, 0, MAX_LAT, 1, -1);
    run_op("neg_inf", 1, 5, 0, 1, 12, 0, 0, 0, 1, 0, MAX_LAT, 1, -1);
    run_op("y0_dbl_inf", 3, 0, 0, 3, 0, 0, 0, 0, 1, 0, MAX_LAT, 0, -1);
    run_op("inf1_q", 0, 0, 1, 2, 7, 0, 2, 7, 0, 0, 4, 0, -1);
    run_op("inf2_p", 5, 8, 0, 0, 0, 1, 5, 8, 0, 0, 4, 0, -1);
    run_op("err_x1", 18, 5, 0, 2, 7, 0, 0, 0, 1, 1, MAX_LAT, 0, -1);
    run_op("busy_start", 1, 5, 0, 2, 7, 0, 1, 12, 0, 0, MAX_LAT, 0, 10);
    hold_check("busy_start", 1, 12, 0, 0);

    // abort an operation 20 cycles in with reset
    @(negedge Clk);
    x1 = W'(1); y1 = W'(5); inf1 = 1'b0; x2 = W'(2); y2 = W'(7); inf2 = 1'b0;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (19) @(negedge Clk);
    check_val("abort_busy_before", 32'(busy), 32'd1);
    Reset = 1'b1;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_x3", 32'(x3), 32'd0);
    check_val("abort_y3", 32'(y3), 32'd0);
    check_val("abort_inf3", 32'(inf3), 32'd0);
    check_val("abort_err", 32'(err), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    dones = 0;
    repeat (180) begin
      @(negedge Clk);
      if (done) dones++;
    end
    check_val("abort_no_done", 32'(dones), 32'd0);
    run_op("after_abort", 1, 5, 0, 2, 7, 0, 1, 12, 0, 0, MAX_LAT, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
